plru_tree_lv1: RTL
==================

// Module: plru_tree_lv1
// PURPOSE
//  Parametrised tree pseudo-LRU replacement tracker for the L1 cache.
//  Supports any power-of-2 associativity, with per-set state held in registers.
//  Victim selection prefers invalid ways, and a same-cycle update is bypassed into the lookup.
//  A sequential sweep (init/flush) resets all sets. Sits beside the L1 tag array, driven by the main cache FSM.
// PARAMETERS
//  ASSOC       4   number of ways; power of 2, >=2
//  WAY_WID     2   $clog2(ASSOC)
//  NUM_SETS    64  number of sets; power of 2
//  IDX_WID     6   $clog2(NUM_SETS)
// PORTS
//  clk                  in   1        single clock; all state updates on posedge
//  rst                  in   1        asynchronous, active-high reset
//  lkp_index            in   IDX_WID  set being looked up for replacement
//  lkp_valid_vec        in   ASSOC    valid bits of the looked-up set, bit i = way i
//  victim_way           out  WAY_WID  way to replace
//  victim_from_invalid  out  1        1 = victim chosen because it is invalid
//  upd_en               in   1        access (hit or fill) to record this cycle
//  upd_index            in   IDX_WID  set of the access
//  upd_way              in   WAY_WID  way accessed
//  init_req             in   1        pulse: start clearing all sets
//  init_busy            out  1        sweep in progress
// BEHAVIOUR
//  State per set: ASSOC-1 bits, heap-ordered.
//   - Node 0 is the root; the children of node n are 2n+1 and 2n+2.
//   - Bit 0 = victim lies in the left (lower-way) half; bit 1 = right half.
//  Reset (async, rst=1): all tree bits 0, FSM=IDLE, sweep counter 0.
//   - While in reset: init_busy=0, victim_way=0, victim_from_invalid=0.
//  Victim (combinational, 0-cycle):
//   - If lkp_valid_vec != all-ones: victim = lowest-index 0 bit, victim_from_invalid=1.
//   - Otherwise: walk the tree from the root, following each node bit; victim_from_invalid=0.
//   - Bypass: if upd_en && upd_index==lkp_index in the same cycle, the walk uses the post-update tree.
//  Update (registered):
//   - On a posedge with upd_en=1 in IDLE, every node on the path to upd_way is set to point away from it.
//   - Bit = 1 if upd_way went left at that node, 0 if it went right; nodes off the path are unchanged.
//   - New state is visible to lookup on the next cycle (same cycle via the bypass).
//  FSM: IDLE, SWEEP.
//   - IDLE -> SWEEP on init_req=1; sweep counter cleared to 0.
//   - SWEEP: each cycle, zero set[cnt], then cnt++.
//   - SWEEP -> IDLE after the cycle that clears set NUM_SETS-1. Duration is exactly NUM_SETS cycles.
//   - init_busy=1 in every SWEEP cycle.
//   - During SWEEP: upd_en is ignored, victim_way=0, victim_from_invalid=0.
//   - init_req during SWEEP is ignored; it does not restart the sweep.
//   - init_req together with upd_en in IDLE: the sweep wins and the update is dropped.
//  Reset mid-sweep: immediate return to IDLE, all state zero, init_busy=0.
//  ASSOC=4 encoding {n2,n1,n0}: victim way0=?x00 (n0=0,n1=0), way1=?x10, way2=0?1, way3=1?1.
// STRUCTURE
//  Shared package lv1_cache_pkg holds:
//   - ASSOC, WAY_WID, NUM_SETS, IDX_WID constants.
//   - typedef plru_state_t (logic [ASSOC-2:0]).
//   - typedef enum {IDLE, SWEEP} plru_fsm_e.
//  Sub-module plru_tree_walk (combinational): tree state -> way.
//   - Instantiated once for the lookup path.
//  The path-update next-state is a package function plru_touch(state, way).
//   - The bypass reuses it: plru_touch feeds plru_tree_walk.
// TESTING
//  1 Reset, valid_vec=4'hF, any index -> victim_way=0, from_invalid=0, init_busy=0.
//  2 ASSOC=4, set 5, upd ways 0,1,2,3 on successive cycles -> next-cycle victims 2,2,0,0.
//  3 valid_vec=4'b1011 with any tree state -> victim_way=2, from_invalid=1; 4'b0000 -> victim_way=0.
//  4 From reset, upd_en=1 idx=3 way=0 with lkp_index=3 same cycle -> victim_way=2 that cycle.
//  5 Train sets 0..63, pulse init_req with upd_en active -> init_busy high exactly 64 cycles.
//    -> Updates during the sweep are dropped; afterwards every set gives victim 0.
//  6 ASSOC=8: upd ways 0..7 in order -> victim 0; rst asserted at sweep cycle 10 -> init_busy=0 immediately.

Source files
------------

// File: rtl/lv1_cache_pkg.sv
// Shared L1 cache constants, types and the tree-PLRU path-update helper.
package lv1_cache_pkg;

    localparam int unsigned ASSOC    = 4;
    localparam int unsigned WAY_WID  = $clog2(ASSOC);
    localparam int unsigned NUM_SETS = 64;
    localparam int unsigned IDX_WID  = $clog2(NUM_SETS);

    // Widest tree the generic helpers handle (64 ways).
    localparam int unsigned MAX_WAY_WID = 6;
    localparam int unsigned MAX_NODES   = (1 << MAX_WAY_WID) - 1;

    typedef logic [ASSOC-2:0] plru_state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } plru_fsm_e;

    // Point every node on the path to 'way' away from it; levels = log2(ways).
    function automatic logic [MAX_NODES-1:0] plru_touch_n(
        input logic [MAX_NODES-1:0]   state,
        input logic [MAX_WAY_WID-1:0] way,
        input int unsigned            levels
    );
        logic [MAX_NODES-1:0]   nxt;
        logic [MAX_WAY_WID-1:0] node;
        logic                   dir;
        nxt  = state;
        node = '0;
        dir  = 1'b0;
        for (int unsigned lvl = 0; lvl < MAX_WAY_WID; lvl++) begin
            if (lvl < levels) begin
                dir       = 1'(way >> (levels - 1 - lvl));
                nxt[node] = ~dir;
                node      = {node[MAX_WAY_WID-2:0], 1'b0} + MAX_WAY_WID'(1) + MAX_WAY_WID'(dir);
            end
        end
        return nxt;
    endfunction

    // Path update at the package's default associativity.
    function automatic plru_state_t plru_touch(
        input plru_state_t        state,
        input logic [WAY_WID-1:0] way
    );
        return (ASSOC-1)'(plru_touch_n(MAX_NODES'(state), MAX_WAY_WID'(way), WAY_WID));
    endfunction

endpackage

// File: rtl/plru_tree_walk.sv
// Combinational walk of a heap-ordered PLRU tree from root to the victim leaf.
module plru_tree_walk #(
    parameter int unsigned ASSOC   = 4,
    parameter int unsigned WAY_WID = $clog2(ASSOC)
) (
    input  logic [ASSOC-2:0]   state,
    output logic [WAY_WID-1:0] way
);
    import lv1_cache_pkg::*;

    logic [MAX_NODES-1:0]   state_ext;
    logic [MAX_WAY_WID-1:0] node;
    logic [MAX_WAY_WID-1:0] path;

    // Follow each node bit (0 = left, 1 = right), collecting the way MSB first.
    always_comb begin
        state_ext = MAX_NODES'(state);
        node      = '0;
        path      = '0;
        for (int unsigned lvl = 0; lvl < MAX_WAY_WID; lvl++) begin
            if (lvl < WAY_WID) begin
                path = {path[MAX_WAY_WID-2:0], state_ext[node]};
                node = {node[MAX_WAY_WID-2:0], 1'b0} + MAX_WAY_WID'(1)
                       + MAX_WAY_WID'(state_ext[node]);
            end
        end
        way = WAY_WID'(path);
    end

endmodule

// File: rtl/plru_tree_lv1.sv
// L1 tree pseudo-LRU tracker: per-set tree state, invalid-first victim choice,
// same-cycle update bypass and a one-set-per-cycle clearing sweep.
module plru_tree_lv1 #(
    parameter int unsigned ASSOC    = lv1_cache_pkg::ASSOC,
    parameter int unsigned WAY_WID  = $clog2(ASSOC),
    parameter int unsigned NUM_SETS = lv1_cache_pkg::NUM_SETS,
    parameter int unsigned IDX_WID  = $clog2(NUM_SETS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_WID-1:0] lkp_index,
    input  logic [ASSOC-1:0]   lkp_valid_vec,
    output logic [WAY_WID-1:0] victim_way,
    output logic               victim_from_invalid,
    input  logic               upd_en,
    input  logic [IDX_WID-1:0] upd_index,
    input  logic [WAY_WID-1:0] upd_way,
    input  logic               init_req,
    output logic               init_busy
);
    import lv1_cache_pkg::*;

    localparam int unsigned NODES = ASSOC - 1;

    logic [NODES-1:0]   tree_q [NUM_SETS];
    plru_fsm_e          fsm_q;
    logic [IDX_WID-1:0] sweep_cnt_q;

    logic               upd_fire_c;
    logic [NODES-1:0]   upd_next_c;
    logic [NODES-1:0]   lkp_state_c;
    logic [WAY_WID-1:0] walk_way_c;
    logic [WAY_WID-1:0] free_way_c;
    logic               has_free_c;

    // An update lands only in IDLE and loses to a simultaneous sweep request.
    always_comb begin
        upd_fire_c  = (fsm_q == IDLE) && upd_en && !init_req;
        upd_next_c  = NODES'(plru_touch_n(MAX_NODES'(tree_q[upd_index]),
                                          MAX_WAY_WID'(upd_way), WAY_WID));
        lkp_state_c = (upd_fire_c && (upd_index == lkp_index)) ? upd_next_c
                                                               : tree_q[lkp_index];
    end

    plru_tree_walk #(
        .ASSOC   (ASSOC),
        .WAY_WID (WAY_WID)
    ) u_walk (
        .state (lkp_state_c),
        .way   (walk_way_c)
    );

    // Lowest-index invalid way, scanned from the top so the lowest wins.
    always_comb begin
        has_free_c = ~&lkp_valid_vec;
        free_way_c = '0;
        for (int i = int'(ASSOC) - 1; i >= 0; i--) begin
            if (!1'(lkp_valid_vec >> i)) begin
                free_way_c = WAY_WID'(i);
            end
        end
    end

    // Victim output; forced to way 0 in reset and while sweeping.
    always_comb begin
        victim_way          = '0;
        victim_from_invalid = 1'b0;
        if (!rst && (fsm_q == IDLE)) begin
            if (has_free_c) begin
                victim_way          = free_way_c;
                victim_from_invalid = 1'b1;
            end else begin
                victim_way = walk_way_c;
            end
        end
    end

    // Sweep FSM and per-set tree storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            sweep_cnt_q <= '0;
            init_busy   <= 1'b0;
            tree_q      <= '{default: '0};
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (init_req) begin
                        fsm_q       <= SWEEP;
                        sweep_cnt_q <= '0;
                        init_busy   <= 1'b1;
                    end else if (upd_fire_c) begin
                        tree_q[upd_index] <= upd_next_c;
                    end
                end
                SWEEP: begin
                    tree_q[sweep_cnt_q] <= '0;
                    sweep_cnt_q         <= sweep_cnt_q + IDX_WID'(1);
                    if (sweep_cnt_q == IDX_WID'(NUM_SETS - 1)) begin
                        fsm_q     <= IDLE;
                        init_busy <= 1'b0;
                    end
                end
                default: begin
                    fsm_q     <= IDLE;
                    init_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
